rtc_alarm: RTL and testbench

RTC_ALARM -- requirements
Module: rtc_alarm

---
 rtl/rtc_pkg.sv | 36 +++
 rtl/rtc_prescaler.sv | 35 +++
 rtl/rtc_alarm.sv | 92 +++++++++
 tb/tb_rtc_alarm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared widths, limits and time type for the real-time clock with alarm.
package rtc_pkg;

  localparam int unsigned HH_W = 5;
  localparam int unsigned MM_W = 6;
  localparam int unsigned SS_W = 6;

  localparam logic [SS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MM_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HH_W-1:0] HR_MAX  = 5'd23;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MM_W-1:0] mm;
    logic [SS_W-1:0] ss;
  } rtc_time_t;

  // One-second advance with minute, hour and midnight carries.
  function automatic rtc_time_t next_second(rtc_time_t t);
    rtc_time_t n;
    n = t;
    if (t.ss == SEC_MAX) begin
      n.ss = '0;
      if (t.mm == MIN_MAX) begin
        n.mm = '0;
        n.hh = (t.hh == HR_MAX) ? '0 : t.hh + 5'd1;
      end else begin
        n.mm = t.mm + 6'd1;
      end
    end else begin
      n.ss = t.ss + 6'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles; clr restarts the count.
module rtc_prescaler #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  // tick is registered from the next count so it is high exactly while cnt_q == LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/rtc_alarm.sv
// 24-hour real-time clock with settable time, HH:MM alarm and 12/24-hour display.
module rtc_alarm import rtc_pkg::*; #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_valid,
  input  logic [16:0] set_time,
  input  logic        alarm_wr,
  input  logic [10:0] alarm_time,
  input  logic        alarm_en,
  input  logic        mode12,
  output logic [4:0]  HH,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [4:0]  disp_hh,
  output logic        pm,
  output logic        tick,
  output logic        day_wrap,
  output logic        alarm,
  output logic        set_err
);

  rtc_time_t              time_q, time_d, set_t, inc_t;
  logic [HH_W+MM_W-1:0]   alm_q, alm_d;
  logic                   wrap_q, wrap_d, alarm_q, alarm_d, err_q, err_d;
  logic                   set_ok, alm_ok, load_ok;

  rtc_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_ok),
    .tick (tick)
  );

  assign set_t   = set_time;
  assign set_ok  = (set_t.hh <= HR_MAX) && (set_t.mm <= MIN_MAX) && (set_t.ss <= SEC_MAX);
  assign alm_ok  = (alarm_time[10:6] <= HR_MAX) && (alarm_time[5:0] <= MIN_MAX);
  assign load_ok = set_valid && set_ok;
  assign inc_t   = next_second(time_q);

  // A valid load takes priority over a coincident tick; an invalid load leaves the tick alone.
  always_comb begin
    time_d  = time_q;
    wrap_d  = 1'b0;
    alarm_d = 1'b0;
    if (load_ok) begin
      time_d = set_t;
    end else if (tick) begin
      time_d  = inc_t;
      wrap_d  = (inc_t == '0);
      alarm_d = alarm_en && (inc_t.hh == alm_q[10:6]) && (inc_t.mm == alm_q[5:0])
                && (inc_t.ss == '0);
    end
    alm_d = (alarm_wr && alm_ok) ? alarm_time : alm_q;
    err_d = (set_valid && !set_ok) || (alarm_wr && !alm_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= '0;
      alm_q   <= '0;
      wrap_q  <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      time_q  <= time_d;
      alm_q   <= alm_d;
      wrap_q  <= wrap_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
    end
  end

  assign HH       = time_q.hh;
  assign mm       = time_q.mm;
  assign ss       = time_q.ss;
  assign day_wrap = wrap_q;
  assign alarm    = alarm_q;
  assign set_err  = err_q;

  always_comb begin
    disp_hh = HH;
    pm      = 1'b0;
    if (mode12) begin
      pm = (HH >= 5'd12);
      if (HH == '0)         disp_hh = 5'd12;
      else if (HH > 5'd12)  disp_hh = HH - 5'd12;
    end
  end

endmodule

// File: tb/tb_rtc_alarm.sv
// Bench for rtc_alarm (CLK_DIV=4): seconds-of-day reference model plus directed literal checks.
module tb_rtc_alarm;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_valid = 1'b0;
  logic [16:0] set_time = '0;
  logic        alarm_wr = 1'b0;
  logic [10:0] alarm_time = '0;
  logic        alarm_en = 1'b0;
  logic        mode12 = 1'b0;
  logic [4:0]  HH, disp_hh;
  logic [5:0]  mm, ss;
  logic        pm, tick, day_wrap, alarm, set_err;

  rtc_alarm #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .set_valid(set_valid), .set_time(set_time),
    .alarm_wr(alarm_wr), .alarm_time(alarm_time), .alarm_en(alarm_en), .mode12(mode12),
    .HH(HH), .mm(mm), .ss(ss), .disp_hh(disp_hh), .pm(pm), .tick(tick),
    .day_wrap(day_wrap), .alarm(alarm), .set_err(set_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, alarm as minute of day.
  int m_secs = 0, m_pc = 0, m_alm = 0;
  bit e_tick = 0, e_wrap = 0, e_alarm = 0, e_err = 0;

  always @(posedge clk) begin
    int h, m, s, ns;
    bit tick_now, sok, aok;
    if (rst) begin
      m_secs = 0; m_pc = 0; m_alm = 0;
      e_tick = 0; e_wrap = 0; e_alarm = 0; e_err = 0;
    end else begin
      tick_now = e_tick;
      h = set_time[16:12]; m = set_time[11:6]; s = set_time[5:0];
      sok = (h <= 23) && (m <= 59) && (s <= 59);
      aok = (alarm_time[10:6] <= 23) && (alarm_time[5:0] <= 59);
      e_wrap = 0; e_alarm = 0;
      if (set_valid && sok) begin
        m_secs = h * 3600 + m * 60 + s;
        m_pc = 0;
      end else begin
        if (tick_now) begin
          ns = (m_secs + 1) % 86400;
          e_wrap = (ns == 0);
          e_alarm = alarm_en && (ns == m_alm * 60);
          m_secs = ns;
        end
        m_pc = (m_pc + 1) % DIV;
      end
      e_err = (set_valid && !sok) || (alarm_wr && !aok);
      if (alarm_wr && aok) m_alm = alarm_time[10:6] * 60 + alarm_time[5:0];
      e_tick = (m_pc == DIV - 1);
    end
  end

  always @(negedge clk) begin
    int h, dh;
    if (chk_en) begin
      h = m_secs / 3600;
      dh = !mode12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
      chk("HH", HH, h);
      chk("mm", mm, (m_secs / 60) % 60);
      chk("ss", ss, m_secs % 60);
      chk("tick", tick, e_tick);
      chk("day_wrap", day_wrap, e_wrap);
      chk("alarm", alarm, e_alarm);
      chk("set_err", set_err, e_err);
      chk("disp_hh", disp_hh, dh);
      chk("pm", pm, mode12 && h >= 12);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input int h, input int m, input int s);
    set_valid = 1'b1;
    set_time = {5'(h), 6'(m), 6'(s)};
    cyc();
    set_valid = 1'b0;
  endtask

  function automatic int now_secs();
    return int'(HH) * 3600 + int'(mm) * 60 + int'(ss);
  endfunction

  initial begin
    int n, first, wraps, wrap_at, pulses, r, kind, a, t;
    int last_alm;
    last_alm = 0;

    cyc();
    rst = 1'b0;
    chk_en = 1;

    // 240 cycles from reset: one minute of ticks, first tick in the 4th cycle
    n = 0; first = -1; pulses = 0;
    for (int i = 0; i < 240; i++) begin
      if (tick) begin n++; if (first < 0) first = i; end
      if (alarm) pulses++;
      cyc();
    end
    chk("ticks_in_240", n, 60);
    chk("first_tick_cycle", first, 3);
    chk("alarms_in_240", pulses, 0);
    chk("time_after_240", now_secs(), 60);

    // midnight rollover
    do_set(23, 59, 58);
    chk("load_235958", now_secs(), 86398);
    wraps = 0; wrap_at = -1;
    for (int i = 0; i <= 8; i++) begin
      if (day_wrap) begin wraps++; wrap_at = i; end
      if (i < 8) cyc();
    end
    chk("midnight_time", now_secs(), 0);
    chk("day_wrap_count", wraps, 1);
    chk("day_wrap_at", wrap_at, 8);
    cyc();
    chk("day_wrap_clear", day_wrap, 0);

    // rejected writes
    do_set(0, 0, 60);
    chk("bad_set_err", set_err, 1);
    chk("bad_set_time", now_secs(), 0);
    cyc();
    chk("set_err_clear", set_err, 0);
    alarm_wr = 1'b1; alarm_time = {5'd24, 6'd0};
    cyc();
    alarm_wr = 1'b0;
    chk("bad_alarm_err", set_err, 1);

    // alarm at 07:30
    alarm_wr = 1'b1; alarm_time = {5'd7, 6'd30}; alarm_en = 1'b1;
    cyc();
    alarm_wr = 1'b0;
    do_set(7, 29, 59);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (alarm) pulses++;
      cyc();
    end
    chk("early_alarm", pulses, 0);
    chk("alarm_pulse", alarm, 1);
    chk("alarm_time", now_secs(), 7 * 3600 + 30 * 60);
    cyc();
    chk("alarm_one_cycle", alarm, 0);
    alarm_en = 1'b0;
    do_set(7, 29, 59);
    repeat (4) cyc();
    chk("alarm_disabled", alarm, 0);
    chk("alarm_dis_time", now_secs(), 7 * 3600 + 30 * 60);
    alarm_en = 1'b1;
    do_set(7, 30, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (alarm) pulses++;
      cyc();
    end
    chk("alarm_on_load", pulses, 0);

    // 12-hour display
    mode12 = 1'b1;
    do_set(0, 0, 0);
    chk("disp_h0", disp_hh, 12); chk("pm_h0", pm, 0);
    do_set(12, 0, 0);
    chk("disp_h12", disp_hh, 12); chk("pm_h12", pm, 1);
    do_set(13, 0, 0);
    chk("disp_h13", disp_hh, 1); chk("pm_h13", pm, 1);
    mode12 = 1'b0;
    #1;
    chk("disp24_h13", disp_hh, 13); chk("pm24_h13", pm, 0);

    // set coincident with tick
    do_set(1, 2, 3);
    repeat (3) cyc();
    chk("tick_before_set", tick, 1);
    do_set(10, 0, 0);
    chk("set_wins_tick", now_secs(), 36000);

    // reset mid-count
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_time", now_secs(), 0);
    n = 0;
    while (!tick && n < 20) begin cyc(); n++; end
    chk("tick_after_rst", n, 3);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      set_valid = (r < 3) || (r == 5);
      alarm_wr  = (r >= 3 && r <= 5);
      if (set_valid) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: set_time = {5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
          1: set_time = {5'd23, 6'd59, 6'($urandom_range(50, 59))};
          2: begin
            t = (last_alm * 60 + 86400 - $urandom_range(1, 3)) % 86400;
            set_time = {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
          end
          default: set_time = {5'($urandom_range(0, 23)), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
        endcase
      end
      if (alarm_wr) begin
        alarm_time = {5'($urandom_range(0, 25)), 6'($urandom_range(0, 61))};
        a = alarm_time[10:6] * 60 + alarm_time[5:0];
        if (alarm_time[10:6] <= 23 && alarm_time[5:0] <= 59) last_alm = a;
      end
      alarm_en = ($urandom_range(0, 3) != 0);
      mode12   = $urandom_range(0, 1);
      rst      = ($urandom_range(0, 599) == 0);
      if (rst) last_alm = 0;
      cyc();
    end
    set_valid = 1'b0; alarm_wr = 1'b0; rst = 1'b0;
    repeat (4) cyc();
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
